td4x_core: RTL

Parametrised successor to the team's 4-bit TD4-style CPU core. Executes one instruction per cycle when `step` is high, with configurable data and program-counter widths. Compared with the previous core, it adds a defined carry-flag update, a jump that takes priority over the PC increment, an `ADD A,B` instruction, a `HLT` state and an output-write strobe. Sits between the external program ROM (addressed by `pc`, returning `opcode`/`immediate`) and the board I/O.

---
 rtl/td4x_core.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style CPU core.
//
// Executes one instruction per rising clock edge while in RUN with step=1.
// The program ROM sits outside the core. It is addressed by pc and returns
// opcode/immediate for that address in the same cycle.
//
// Parameters:
//   DATA_WIDTH  width of A, B, OUT, immediate and io_in (4..16)
//   ADDR_WIDTH  width of the program counter (2..16)
//
// Ports:
//   clk         core clock, rising edge
//   rst         asynchronous, active-high reset
//   step        execute the presented instruction this cycle
//   opcode      4-bit opcode for the current pc
//   immediate   immediate operand for the current pc
//   io_in       input port, sampled by IN A / IN B
//   pc          program counter / ROM address
//   reg_a       register A
//   reg_b       register B
//   out_port    output register
//   out_strobe  one-cycle pulse in the cycle after out_port is written
//   carry       carry flag from the immediately preceding instruction
//   halted      core is in the HALT state
module td4x_core #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] reg_a,
    output logic [DATA_WIDTH-1:0] reg_b,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_strobe,
    output logic                  carry,
    output logic                  halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD_A_IMM = 4'b0000;
    localparam logic [3:0] OP_ADD_A_B   = 4'b0001;
    localparam logic [3:0] OP_ADD_B_IMM = 4'b1010;
    localparam logic [3:0] OP_MOV_A_IMM = 4'b1100;
    localparam logic [3:0] OP_MOV_B_IMM = 4'b1110;
    localparam logic [3:0] OP_MOV_A_B   = 4'b1000;
    localparam logic [3:0] OP_MOV_B_A   = 4'b0010;
    localparam logic [3:0] OP_IN_A      = 4'b0100;
    localparam logic [3:0] OP_IN_B      = 4'b0110;
    localparam logic [3:0] OP_OUT_B     = 4'b1001;
    localparam logic [3:0] OP_OUT_IMM   = 4'b1101;
    localparam logic [3:0] OP_JMP       = 4'b1111;
    localparam logic [3:0] OP_JNC       = 4'b0111;
    localparam logic [3:0] OP_HLT       = 4'b1011;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_strobe;
    logic                  r_carry;

    logic [DATA_WIDTH:0]   w_sum_a_imm;
    logic [DATA_WIDTH:0]   w_sum_a_b;
    logic [DATA_WIDTH:0]   w_sum_b_imm;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_exec;

    // One extra bit on each sum captures the carry out of the adder.
    assign w_sum_a_imm = {1'b0, r_a} + {1'b0, immediate};
    assign w_sum_a_b   = {1'b0, r_a} + {1'b0, r_b};
    assign w_sum_b_imm = {1'b0, r_b} + {1'b0, immediate};

    assign w_pc_next = r_pc + PC_ONE;
    assign w_exec    = (r_state == ST_RUN) && step;

    // Jump target: truncate the immediate when it is wider than the PC,
    // zero-extend it when it is narrower.
    generate
        if (ADDR_WIDTH <= DATA_WIDTH) begin : g_target_trunc
            assign w_target = immediate[ADDR_WIDTH-1:0];
        end else begin : g_target_ext
            assign w_target = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, immediate};
        end
    endgenerate

    // Whole core state machine. A stall (step=0) or HALT freezes every
    // register except the strobe, which always drops back to 0. An executed
    // instruction defaults to clearing carry and incrementing the PC; the
    // case below overrides those defaults for ADDs, taken jumps and HLT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_strobe <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_exec) begin
                r_carry <= 1'b0;
                r_pc    <= w_pc_next;
                case (opcode)
                    OP_ADD_A_IMM: {r_carry, r_a} <= w_sum_a_imm;
                    OP_ADD_A_B:   {r_carry, r_a} <= w_sum_a_b;
                    OP_ADD_B_IMM: {r_carry, r_b} <= w_sum_b_imm;
                    OP_MOV_A_IMM: r_a <= immediate;
                    OP_MOV_B_IMM: r_b <= immediate;
                    OP_MOV_A_B:   r_a <= r_b;
                    OP_MOV_B_A:   r_b <= r_a;
                    OP_IN_A:      r_a <= io_in;
                    OP_IN_B:      r_b <= io_in;
                    OP_OUT_B: begin
                        r_out    <= r_b;
                        r_strobe <= 1'b1;
                    end
                    OP_OUT_IMM: begin
                        r_out    <= immediate;
                        r_strobe <= 1'b1;
                    end
                    OP_JMP:       r_pc <= w_target;
                    OP_JNC: begin
                        // JNC looks at the carry left by the previous instruction.
                        if (!r_carry) begin
                            r_pc <= w_target;
                        end
                    end
                    OP_HLT: begin
                        r_pc    <= r_pc;
                        r_state <= ST_HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc         = r_pc;
    assign reg_a      = r_a;
    assign reg_b      = r_b;
    assign out_port   = r_out;
    assign out_strobe = r_strobe;
    assign carry      = r_carry;
    assign halted     = (r_state == ST_HALT);

endmodule
